// File: rtl/fetch_defs.sv
// rtl/fetch_defs.sv - shared fetch-unit types and default constants
package fetch_defs;

   localparam int DEF_XLEN  = 32;
   localparam int DEF_ILEN  = 32;
   localparam int DEF_DEPTH = 4;
   localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [DEF_ILEN-1:0] instr;
      logic [DEF_XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of fetched words with flush and occupancy count
module fetch_fifo
   import fetch_defs::*;
#(
   parameter int  DEPTH   = DEF_DEPTH,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  entry_t                       push_data,
   input  logic                         pop,
   output entry_t                       pop_data,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign pop_data = mem[rptr];
   assign empty    = (count == '0);

   // The issue credit rule in the parent is what keeps this from ever firing.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && !flush && count == CW'(DEPTH)));

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit with prefetch FIFO and redirect/flush
// Optional misaligned-redirect trap: IFETCH_MISALIGN_TRAP_EN.
module ifetch
   import fetch_defs::*;
#(
   parameter int               XLEN     = DEF_XLEN,
   parameter int               ILEN     = DEF_ILEN,
   parameter int               DEPTH    = DEF_DEPTH,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEF_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [ILEN-1:0]   imem_rsp_data,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [ILEN-1:0]   instr,
   output logic [XLEN-1:0]   instr_pc,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              fetch_fault
);

   localparam int CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } entry_t;

   logic [XLEN-1:0]  fetch_pc;
   logic [XLEN-1:0]  rsp_pc;
   logic [XLEN-1:0]  redir_pc;
   logic [CW-1:0]    inflight;
   logic [CW-1:0]    inflight_nxt;
   logic [CW-1:0]    drop;
   logic [CW-1:0]    fifo_count;
   logic [CW:0]      occ;
   logic             fifo_empty;
   logic             req_fire;
   logic             keep;
   logic             pop;
   entry_t           head;

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic fault_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fault_q <= 1'b0;
      else if (redirect_valid)
         fault_q <= (redirect_pc[1:0] != 2'b00);
   end

   assign fetch_fault = fault_q;
   assign redir_pc    = redirect_pc;
`else
   assign fetch_fault = 1'b0;
   assign redir_pc    = redirect_pc & ~XLEN'(3);
`endif

   // Credits cover both buffered and still-outstanding words.
   assign occ            = {1'b0, inflight} + {1'b0, fifo_count};
   assign imem_req_valid = !rst && !redirect_valid && !fetch_fault && (occ < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign keep        = imem_rsp_valid && (drop == '0) && !redirect_valid;
   assign instr_valid = !fifo_empty && !redirect_valid;
   assign pop         = instr_valid && instr_ready;
   assign instr       = head.instr;
   assign instr_pc    = head.pc;

   always_comb begin
      inflight_nxt = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
      end else begin
         inflight <= inflight_nxt;
         if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            fetch_pc <= redir_pc;
            rsp_pc   <= redir_pc;
            drop     <= inflight_nxt;
         end else begin
            if (req_fire)
               fetch_pc <= fetch_pc + XLEN'(4);
            if (imem_rsp_valid) begin
               if (drop != '0)
                  drop <= drop - CW'(1);
               else
                  rsp_pc <= rsp_pc + XLEN'(4);
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (keep),
      .push_data (entry_t'{instr: imem_rsp_data, pc: rsp_pc}),
      .pop       (pop),
      .pop_data  (head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed self-checking bench for ifetch
module tb_ifetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ifetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_fault    (fetch_fault)
   );

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Fixed-latency in-order memory model
   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       q[$];
   int          cyc = 0;
   int          lat = 1;
   logic        m_fire;
   logic        m_took;
   logic [31:0] m_addr;

   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         m_fire = imem_req_valid && imem_req_ready;
         m_addr = imem_req_addr;
         m_took = imem_rsp_valid;
         @(posedge clk);
         #1;
         cyc++;
         if (rst) begin
            q.delete();
         end else begin
            if (m_took && q.size() > 0)
               void'(q.pop_front());
            if (m_fire)
               q.push_back('{m_addr, cyc + lat - 1});
         end
         if (q.size() > 0 && q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mdata(q[0].addr);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int l);
      rst = 1'b1;
      step();
      step();
      lat = l;
      rst = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      step();
      redirect_valid = 1'b0;
   endtask

   task automatic wait_instr(output logic found);
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         @(negedge clk);
         if (instr_valid) begin
            found = 1'b1;
            return;
         end
      end
   endtask

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [31:0] addr;
      logic        iv;
      logic [31:0] pc;
   } vec_t;

   vec_t vec [14];
   logic found;

   initial begin
      #300000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      vec[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      vec[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
      vec[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
      vec[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
      vec[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
      vec[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
      vec[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
      vec[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
      vec[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
      vec[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
      vec[10] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
      vec[11] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
      vec[12] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
      vec[13] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};

      rst            = 1'b1;
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset req_valid", 32'(imem_req_valid), 32'd0);
      check("reset instr_valid", 32'(instr_valid), 32'd0);
      check("reset fetch_fault", 32'(fetch_fault), 32'd0);

      // Streaming, then backpressure until credits run out, then resume
      step();
      rst = 1'b0;
      for (int i = 0; i < 14; i++) begin
         instr_ready = vec[i].rdy;
         @(negedge clk);
         check($sformatf("stream%0d req_valid", i), 32'(imem_req_valid), 32'(vec[i].rv));
         if (vec[i].rv)
            check($sformatf("stream%0d req_addr", i), imem_req_addr, vec[i].addr);
         check($sformatf("stream%0d instr_valid", i), 32'(instr_valid), 32'(vec[i].iv));
         if (vec[i].iv) begin
            check($sformatf("stream%0d instr_pc", i), instr_pc, vec[i].pc);
            check($sformatf("stream%0d instr", i), instr, mdata(vec[i].pc));
         end
         step();
      end

      // Redirect with two stale requests in flight, 3-cycle memory
      instr_ready = 1'b1;
      do_reset(3);
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      @(negedge clk);
      check("lat3 redirect req_valid", 32'(imem_req_valid), 32'd0);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("lat3 post req_addr", imem_req_addr, 32'h100);
      check("lat3 post instr_valid", 32'(instr_valid), 32'd0);
      wait_instr(found);
      check("lat3 instr found", 32'(found), 32'd1);
      check("lat3 instr_pc", instr_pc, 32'h100);
      check("lat3 instr", instr, mdata(32'h100));

      // Redirect concurrent with a response and a would-be pop
      do_reset(1);
      step();
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      @(negedge clk);
      check("conc instr_valid masked", 32'(instr_valid), 32'd0);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("conc fifo empty", 32'(instr_valid), 32'd0);
      check("conc req_addr", imem_req_addr, 32'h300);
      step();
      @(negedge clk);
      check("conc wait instr_valid", 32'(instr_valid), 32'd0);
      step();
      @(negedge clk);
      check("conc instr_valid", 32'(instr_valid), 32'd1);
      check("conc instr_pc", instr_pc, 32'h300);
      step();

      // PC wrap at the top of the address space
      redirect(32'hFFFF_FFF8);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("wrap%0d req_addr", k), imem_req_addr, 32'hFFFF_FFF8 + 32'(4 * k));
         check($sformatf("wrap%0d instr_valid", k), 32'(instr_valid), 32'(k >= 2));
         if (k >= 2)
            check($sformatf("wrap%0d instr_pc", k), instr_pc, 32'hFFFF_FFF8 + 32'(4 * (k - 2)));
         step();
      end

      // Misaligned redirect
      redirect(32'h102);
`ifdef IFETCH_MISALIGN_TRAP_EN
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("trap%0d fetch_fault", k), 32'(fetch_fault), 32'd1);
         check($sformatf("trap%0d req_valid", k), 32'(imem_req_valid), 32'd0);
         check($sformatf("trap%0d instr_valid", k), 32'(instr_valid), 32'd0);
         step();
      end
      redirect(32'h200);
      @(negedge clk);
      check("trap clear fetch_fault", 32'(fetch_fault), 32'd0);
      check("trap clear req_addr", imem_req_addr, 32'h200);
      wait_instr(found);
      check("trap resume found", 32'(found), 32'd1);
      check("trap resume instr_pc", instr_pc, 32'h200);
`else
      @(negedge clk);
      check("misalign fetch_fault", 32'(fetch_fault), 32'd0);
      check("misalign req_valid", 32'(imem_req_valid), 32'd1);
      check("misalign req_addr", imem_req_addr, 32'h100);
      wait_instr(found);
      check("misalign found", 32'(found), 32'd1);
      check("misalign instr_pc", instr_pc, 32'h100);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch.md
# ifetch

Parametrised instruction-fetch unit that replaces the static instruction wire feeding the controller/datapath pair in the cpu top level. Owns the fetch PC and issues in-order word requests to instruction memory over a valid/ready request channel with a fixed-order response channel. Buffers returned words in a prefetch FIFO and hands them to decode with their PC over a valid/ready handshake. Supports branch/jump redirect with flush and discard of in-flight responses.

## Interface

Parameters:
- XLEN, 32, PC and address width.
- ILEN, 32, instruction word width.
- DEPTH, 4, prefetch FIFO entries and maximum in-flight plus buffered words; power of two, ≥2.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- imem_req_valid  out  1  request presented.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word address of request (bits [1:0] = 0).
- imem_rsp_valid  in  1  response word valid; one per accepted request, in order, latency ≥1 cycle.
- imem_rsp_data  in  ILEN  response word.
- instr_valid  out  1  instr/instr_pc valid to decode.
- instr_ready  in  1  decode consumes.
- instr  out  ILEN  instruction word.
- instr_pc  out  XLEN  address of instr.
- redirect_valid  in  1  one-cycle redirect request.
- redirect_pc  in  XLEN  new fetch PC.
- fetch_fault  out  1  misaligned-redirect fault (see Configuration).

## Operation

- State: fetch_pc, FIFO (data + pc), inflight count, drop count; counters $clog2(DEPTH+1) bits.
- Issue: imem_req_valid = !rst_state && !redirect_valid && !fetch_fault && (inflight + fifo_count < DEPTH). imem_req_addr = fetch_pc. On req fire: fetch_pc += 4 (wraps modulo 2^XLEN), inflight += 1.
- Response: on imem_rsp_valid, inflight -= 1; if drop count > 0, word discarded and drop count -= 1; else pushed with its PC (tracked by a response-side PC register, advanced by 4 per kept word). Credit rule guarantees FIFO never overflows; response on full FIFO is an assertion error.
- Output: instr_valid = FIFO non-empty && !redirect_valid; pop on instr_valid && instr_ready.
- Redirect (redirect_valid high): next edge FIFO emptied, fetch_pc and response-side PC ← redirect_pc, drop count ← inflight after this cycle's fire/response accounting (response arriving this cycle is discarded as stale). No request issued and no pop recorded in the redirect cycle.
- Simultaneous request fire and response: inflight unchanged.
- Back-to-back redirects: last one wins; drop count recomputed each time.

## Timing

- Reset values: imem_req_valid 0 during rst, instr_valid 0, fetch_fault 0, fetch_pc RESET_PC, counts 0, FIFO empty.
- First request: first cycle after rst deasserts, addr = RESET_PC.
- Response → instr_valid: 1 cycle (registered FIFO, no bypass).
- Redirect → first request at redirect_pc: cycle after redirect_valid.
- Steady state with 1-cycle memory and instr_ready held high: one instruction per cycle.
- rst mid-operation: all state cleared immediately; outstanding memory responses after rst deassertion are the memory's responsibility to cancel.

## Configuration

- IFETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0] != 0 sets fetch_fault next edge, FIFO flushed, issue halted; fetch_fault cleared by a subsequent aligned redirect or rst.
- Undefined: redirect_pc[1:0] forced to 0; fetch_fault tied to 0.

## Structure

- Shared package fetch_defs: fetch_entry_t (instr, pc), RESET_PC default constant, DEPTH default constant.
- One sub-module: fetch_fifo (parametrised DEPTH synchronous FIFO of fetch_entry_t, flush input, count output).

## Test plan

- Reset, memory ready always, 1-cycle latency, instr_ready=1 → requests 0x0,0x4,0x8…; instr_pc 0x0 appears 2 cycles after first req fire, then one per cycle.
- instr_ready=0, DEPTH=4 → exactly 4 requests issued, then imem_req_valid stays 0; raising instr_ready resumes issue.
- Memory latency 3 cycles, redirect to 0x100 with 2 requests in flight → both stale responses dropped, next instr_pc is 0x100.
- Redirect concurrent with response and with instr_ready=1 → response discarded, no pop counted, FIFO empty next cycle.
- fetch_pc 0xFFFF_FFFC (XLEN=32) → next request addr 0x0000_0000.
- With IFETCH_MISALIGN_TRAP_EN, redirect to 0x102 → fetch_fault=1, no requests; redirect to 0x200 → fault clears, fetch resumes at 0x200; without macro, fetch resumes at 0x100.
